// File: rtl/vec_alu_ctrl.sv
// Vector ALU lane sequencer: accepts one request, runs the selected lanes until each reports done
// (or the watchdog expires), assembles the lane slices into a VLEN-bit result and returns it.
module vec_alu_ctrl #(
    parameter int unsigned VLEN       = 128,
    parameter int unsigned LANE_WIDTH = 4,
    parameter int unsigned NLANES     = 4,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [5:0]           req_opcode,
    input  logic [2:0]           req_op_type,
    input  logic [2:0]           req_vsew,
    input  logic [1:0]           req_nb_lanes,
    input  logic [VLEN-1:0]      req_vs1,
    input  logic [VLEN-1:0]      req_vs2,
    input  logic [63:0]          req_scalar,
    input  logic [4:0]           req_imm,
    output logic [NLANES-1:0]    lane_run,
    output logic [5:0]           lane_opcode,
    output logic [2:0]           lane_vsew,
    output logic [2:0]           lane_op_type,
    output logic [1:0]           lane_nb_lanes,
    output logic [VLEN-1:0]      lane_vs1,
    output logic [VLEN-1:0]      lane_vs2,
    input  logic [NLANES*64-1:0] lane_vd,
    input  logic [NLANES*10-1:0] lane_index,
    input  logic [NLANES-1:0]    lane_done,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [VLEN-1:0]      resp_vd,
    output logic                 resp_err
);

    localparam int unsigned LW = 1 << LANE_WIDTH;

    typedef enum logic [1:0] {StIdle, StRun, StResp} state_e;

    state_e              state_q, state_d;
    logic [5:0]          opcode_q, opcode_d;
    logic [2:0]          op_type_q, op_type_d;
    logic [2:0]          vsew_q, vsew_d;
    logic [1:0]          nb_lanes_q, nb_lanes_d;
    logic [VLEN-1:0]     vs1_q, vs1_d;
    logic [VLEN-1:0]     vs2_q, vs2_d;
    logic [VLEN-1:0]     resp_vd_q, resp_vd_d;
    logic                resp_err_q, resp_err_d;
    logic [NLANES-1:0]   sticky_q, sticky_d;
    logic [NLANES-1:0]   lane_run_q, lane_run_d;
    logic [9:0]          wdog_q, wdog_d;

    logic [63:0]         sew_mask;
    logic [63:0]         imm_sext;
    logic [VLEN-1:0]     vs1_built;
    logic                illegal;
    logic [NLANES-1:0]   active;
    logic                unused_lane_vd;

    function automatic logic [NLANES-1:0] lane_mask(input logic [1:0] nb);
        logic [NLANES-1:0] m;
        for (int i = 0; i < int'(NLANES); i++) begin
            m[i] = (i < (1 << nb));
        end
        return m;
    endfunction

    // Only the low LW bits of each lane result are meaningful.
    assign unused_lane_vd = ^lane_vd;

    always_comb begin
        sew_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        case (req_vsew[1:0])
            2'd0:    sew_mask = 64'h0000_0000_0000_00FF;
            2'd1:    sew_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    sew_mask = 64'h0000_0000_FFFF_FFFF;
            default: sew_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        imm_sext = {{59{req_imm[4]}}, req_imm};
        case (req_op_type)
            3'b010:  vs1_built = VLEN'(req_scalar & sew_mask);
            3'b100:  vs1_built = VLEN'(imm_sext & sew_mask);
            default: vs1_built = req_vs1;
        endcase
        illegal = req_vsew[2] || !$onehot(req_op_type) || ((32'd1 << req_nb_lanes) > NLANES);
    end

    assign active = lane_mask(nb_lanes_q);

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        op_type_d  = op_type_q;
        vsew_d     = vsew_q;
        nb_lanes_d = nb_lanes_q;
        vs1_d      = vs1_q;
        vs2_d      = vs2_q;
        resp_vd_d  = resp_vd_q;
        resp_err_d = resp_err_q;
        sticky_d   = sticky_q;
        lane_run_d = lane_run_q;
        wdog_d     = wdog_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    opcode_d   = req_opcode;
                    op_type_d  = req_op_type;
                    vsew_d     = req_vsew;
                    nb_lanes_d = req_nb_lanes;
                    vs1_d      = vs1_built;
                    vs2_d      = req_vs2;
                    resp_vd_d  = '0;
                    sticky_d   = '0;
                    wdog_d     = '0;
                    if (illegal) begin
                        state_d    = StResp;
                        resp_err_d = 1'b1;
                        lane_run_d = '0;
                    end else begin
                        state_d    = StRun;
                        resp_err_d = 1'b0;
                        lane_run_d = lane_mask(req_nb_lanes);
                    end
                end
            end
            StRun: begin
                wdog_d = wdog_q + 10'd1;
                for (int i = 0; i < int'(NLANES); i++) begin
                    if (lane_run_q[i]) begin
                        if (lane_done[i]) begin
                            sticky_d[i] = 1'b1;
                        end else if (int'(lane_index[10*i +: 10]) + int'(LW) <= int'(VLEN)) begin
                            resp_vd_d[int'(lane_index[10*i +: 10]) +: LW] = lane_vd[64*i +: LW];
                        end
                    end
                end
                // Completion wins over a watchdog expiry in the same cycle.
                if ((sticky_q & active) == active) begin
                    state_d    = StResp;
                    resp_err_d = 1'b0;
                    lane_run_d = '0;
                end else if (wdog_d == 10'(TIMEOUT)) begin
                    state_d    = StResp;
                    resp_err_d = 1'b1;
                    lane_run_d = '0;
                end else begin
                    lane_run_d = active & ~sticky_d;
                end
            end
            StResp: begin
                lane_run_d = '0;
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d    = StIdle;
                lane_run_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            opcode_q   <= '0;
            op_type_q  <= '0;
            vsew_q     <= '0;
            nb_lanes_q <= '0;
            vs1_q      <= '0;
            vs2_q      <= '0;
            resp_vd_q  <= '0;
            resp_err_q <= 1'b0;
            sticky_q   <= '0;
            lane_run_q <= '0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            op_type_q  <= op_type_d;
            vsew_q     <= vsew_d;
            nb_lanes_q <= nb_lanes_d;
            vs1_q      <= vs1_d;
            vs2_q      <= vs2_d;
            resp_vd_q  <= resp_vd_d;
            resp_err_q <= resp_err_d;
            sticky_q   <= sticky_d;
            lane_run_q <= lane_run_d;
            wdog_q     <= wdog_d;
        end
    end

    assign req_ready     = (state_q == StIdle);
    assign resp_valid    = (state_q == StResp);
    assign resp_vd       = resp_vd_q;
    assign resp_err      = resp_err_q;
    assign lane_run      = lane_run_q;
    assign lane_opcode   = opcode_q;
    assign lane_vsew     = vsew_q;
    assign lane_op_type  = op_type_q;
    assign lane_nb_lanes = nb_lanes_q;
    assign lane_vs1      = vs1_q;
    assign lane_vs2      = vs2_q;

endmodule

// File: tb/tb_vec_alu_ctrl.sv
// Table-driven bench for vec_alu_ctrl with behavioural lane stubs that stream 16-bit result
// chunks, plus directed sequences for watchdog expiry, reset mid-run and response back-pressure.
module tb_vec_alu_ctrl;

    localparam int VLEN = 128;
    localparam int NL   = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic            req_valid;
    logic            req_ready;
    logic [5:0]      req_opcode;
    logic [2:0]      req_op_type;
    logic [2:0]      req_vsew;
    logic [1:0]      req_nb_lanes;
    logic [127:0]    req_vs1, req_vs2;
    logic [63:0]     req_scalar;
    logic [4:0]      req_imm;
    logic [3:0]      lane_run;
    logic [5:0]      lane_opcode;
    logic [2:0]      lane_vsew, lane_op_type;
    logic [1:0]      lane_nb_lanes;
    logic [127:0]    lane_vs1, lane_vs2;
    logic [255:0]    lane_vd;
    logic [39:0]     lane_index;
    logic [3:0]      lane_done;
    logic            resp_valid;
    logic            resp_ready;
    logic [127:0]    resp_vd;
    logic            resp_err;

    logic            nodone;
    logic [127:0]    lane_res;
    int              cnt[NL];
    int              checks = 0;
    int              passed = 0;

    always #5 clk = ~clk;

    vec_alu_ctrl #(.VLEN(128), .LANE_WIDTH(4), .NLANES(4), .TIMEOUT(16)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_op_type(req_op_type), .req_vsew(req_vsew),
        .req_nb_lanes(req_nb_lanes), .req_vs1(req_vs1), .req_vs2(req_vs2),
        .req_scalar(req_scalar), .req_imm(req_imm), .lane_run(lane_run),
        .lane_opcode(lane_opcode), .lane_vsew(lane_vsew), .lane_op_type(lane_op_type),
        .lane_nb_lanes(lane_nb_lanes), .lane_vs1(lane_vs1), .lane_vs2(lane_vs2),
        .lane_vd(lane_vd), .lane_index(lane_index), .lane_done(lane_done),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_vd(resp_vd),
        .resp_err(resp_err)
    );

    // Lane reference: VX/VI broadcast the low SEW bits of lane_vs1 to every element.
    function automatic logic [127:0] lane_ref(input logic [5:0] op, input logic [2:0] ot,
                                              input logic [1:0] sew, input logic [127:0] a,
                                              input logic [127:0] b);
        int w;
        logic [63:0] m, s, x, y, r;
        logic [127:0] res;
        w   = 8 << sew;
        m   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        s   = a[63:0] & m;
        res = '0;
        for (int e = 0; e < 128 / w; e++) begin
            x = (ot == 3'b001) ? (64'(a >> (e * w)) & m) : s;
            y = 64'(b >> (e * w)) & m;
            case (op)
                6'b000000: r = x + y;
                6'b001001: r = x & y;
                6'b001010: r = x | y;
                6'b001011: r = x ^ y;
                default:   r = '0;
            endcase
            res = res | (128'(r & m) << (e * w));
        end
        return res;
    endfunction

    always_comb lane_res = lane_ref(lane_opcode, lane_op_type, lane_vsew[1:0], lane_vs1, lane_vs2);

    // Lane i streams chunks i, i+n, ... then pulses done (or parks on a dropped offset).
    always_comb begin
        lane_vd    = '0;
        lane_index = '0;
        lane_done  = '0;
        for (int i = 0; i < NL; i++) begin
            if (lane_run[i]) begin
                int n;
                int chunk;
                n     = 1 << lane_nb_lanes;
                chunk = i + cnt[i] * n;
                if (cnt[i] < 8 / n) begin
                    lane_index[10*i +: 10] = 10'(chunk * 16);
                    lane_vd[64*i +: 16]    = lane_res[chunk*16 +: 16];
                end else if (nodone) begin
                    lane_index[10*i +: 10] = 10'd200;
                end else begin
                    lane_done[i] = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (!resetn || !lane_run[i]) cnt[i] <= 0;
            else                         cnt[i] <= cnt[i] + 1;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [5:0]   op;
        logic [2:0]   ot;
        logic [2:0]   sew;
        logic [1:0]   nb;
        logic [127:0] vs1;
        logic [127:0] vs2;
        logic [63:0]  sc;
        logic [4:0]   imm;
        logic [127:0] exp_vd;
        logic         exp_err;
        logic [3:0]   exp_mask;
        logic [127:0] exp_vs1;
    } vec_t;

    vec_t tbl[9];

    task automatic run_txn(input vec_t v, output logic [127:0] vd, output logic err,
                           output logic [3:0] runmask, output int cyc, output int runcyc,
                           output logic [127:0] vs1_seen, output logic [3:0] run_at_resp,
                           output logic to);
        @(negedge clk);
        req_opcode   = v.op;
        req_op_type  = v.ot;
        req_vsew     = v.sew;
        req_nb_lanes = v.nb;
        req_vs1      = v.vs1;
        req_vs2      = v.vs2;
        req_scalar   = v.sc;
        req_imm      = v.imm;
        req_valid    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0; runcyc = 0; runmask = '0; to = 1'b1;
        vd = '0; err = 1'b0; vs1_seen = '0; run_at_resp = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            cyc++;
            runmask = runmask | lane_run;
            if (lane_run != 0) runcyc++;
            if (k == 0) vs1_seen = lane_vs1;
            if (resp_valid) begin
                vd = resp_vd; err = resp_err; run_at_resp = lane_run; to = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        logic [127:0] vd, vs1_seen;
        logic         err, to;
        logic [3:0]   mask, rar;
        int           cyc, runcyc;

        resetn = 1'b0; req_valid = 1'b0; resp_ready = 1'b1; nodone = 1'b0;
        req_opcode = '0; req_op_type = '0; req_vsew = '0; req_nb_lanes = '0;
        req_vs1 = '0; req_vs2 = '0; req_scalar = '0; req_imm = '0;

        tbl[0] = '{6'b000000, 3'b001, 3'd2, 2'd1, {4{32'h0000_0001}}, {4{32'hFFFF_FFFF}}, 64'd0,
                   5'd0, 128'd0, 1'b0, 4'b0011, {4{32'h0000_0001}}};
        tbl[1] = '{6'b001001, 3'b001, 3'd0, 2'd2, {16{8'hF0}}, {16{8'h3C}}, 64'd0,
                   5'd0, {16{8'h30}}, 1'b0, 4'b1111, {16{8'hF0}}};
        tbl[2] = '{6'b000000, 3'b100, 3'd0, 2'd2, '1, {16{8'h05}}, 64'd0,
                   5'b11111, {16{8'h04}}, 1'b0, 4'b1111, 128'hFF};
        tbl[3] = '{6'b001011, 3'b010, 3'd1, 2'd0, '1, 128'd0, 64'h1234_FFFF,
                   5'd0, {8{16'hFFFF}}, 1'b0, 4'b0001, 128'hFFFF};
        tbl[4] = '{6'b001010, 3'b001, 3'd3, 2'd1, {2{64'hF0F0_0000_1234_0000}},
                   {2{64'h0F0F_0000_0000_5678}}, 64'd0, 5'd0, {2{64'hFFFF_0000_1234_5678}},
                   1'b0, 4'b0011, {2{64'hF0F0_0000_1234_0000}}};
        tbl[5] = '{6'b000000, 3'b001, 3'b101, 2'd1, '1, '1, 64'd0, 5'd0, 128'd0, 1'b1,
                   4'b0000, 128'd0};
        tbl[6] = '{6'b000000, 3'b001, 3'd0, 2'd3, '1, '1, 64'd0, 5'd0, 128'd0, 1'b1,
                   4'b0000, 128'd0};
        tbl[7] = '{6'b001001, 3'b011, 3'd0, 2'd0, '1, '1, 64'd0, 5'd0, 128'd0, 1'b1,
                   4'b0000, 128'd0};
        tbl[8] = '{6'b000000, 3'b100, 3'd2, 2'd2, 128'd0, {4{32'h0000_0011}}, 64'd0,
                   5'b10000, {4{32'h0000_0001}}, 1'b0, 4'b1111, 128'hFFFF_FFF0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 128'(req_ready), 128'd1);
        check("rst_resp_valid", 128'(resp_valid), 128'd0);
        check("rst_lane_run", 128'(lane_run), 128'd0);
        check("rst_resp_vd", resp_vd, 128'd0);
        check("rst_resp_err", 128'(resp_err), 128'd0);
        check("rst_lane_vs2", lane_vs2, 128'd0);
        resetn = 1'b1;

        for (int t = 0; t < 9; t++) begin
            run_txn(tbl[t], vd, err, mask, cyc, runcyc, vs1_seen, rar, to);
            check($sformatf("v%0d_timeout", t), 128'(to), 128'd0);
            check($sformatf("v%0d_vd", t), vd, tbl[t].exp_vd);
            check($sformatf("v%0d_err", t), 128'(err), 128'(tbl[t].exp_err));
            check($sformatf("v%0d_runmask", t), 128'(mask), 128'(tbl[t].exp_mask));
            if (tbl[t].exp_err) check($sformatf("v%0d_err_fast", t), 128'(cyc <= 2), 128'd1);
            else                check($sformatf("v%0d_vs1", t), vs1_seen, tbl[t].exp_vs1);
        end

        // Watchdog: lanes never report done.
        nodone = 1'b1;
        run_txn('{6'b000000, 3'b001, 3'd0, 2'd2, 128'd0, {8{16'hA55A}}, 64'd0, 5'd0, 128'd0,
                  1'b1, 4'b1111, 128'd0}, vd, err, mask, cyc, runcyc, vs1_seen, rar, to);
        check("wd_timeout_bound", 128'(to), 128'd0);
        check("wd_err", 128'(err), 128'd1);
        check("wd_run_cycles", 128'(runcyc), 128'd16);
        check("wd_run_at_resp", 128'(rar), 128'd0);
        check("wd_partial_vd", vd, {8{16'hA55A}});

        // Reset while lanes are running.
        @(negedge clk);
        req_opcode = 6'b001001; req_op_type = 3'b001; req_vsew = 3'd0; req_nb_lanes = 2'd2;
        req_vs1 = {16{8'hF0}}; req_vs2 = {16{8'h3C}}; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_run_active", 128'(lane_run), 128'hF);
        resetn = 1'b0;
        @(negedge clk);
        check("mr_lane_run", 128'(lane_run), 128'd0);
        check("mr_resp_valid", 128'(resp_valid), 128'd0);
        check("mr_req_ready", 128'(req_ready), 128'd1);
        check("mr_lane_opcode", 128'(lane_opcode), 128'd0);
        check("mr_lane_vs2", lane_vs2, 128'd0);
        resetn = 1'b1;
        nodone = 1'b0;

        // Back-pressure on the response; a pending request must not be taken.
        resp_ready = 1'b0;
        run_txn(tbl[1], vd, err, mask, cyc, runcyc, vs1_seen, rar, to);
        check("bp_reached_resp", 128'(to), 128'd0);
        req_op_type = 3'b011;
        req_valid   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d_valid", k), 128'(resp_valid), 128'd1);
            check($sformatf("bp%0d_vd", k), resp_vd, {16{8'h30}});
            check($sformatf("bp%0d_err", k), 128'(resp_err), 128'd0);
            check($sformatf("bp%0d_req_ready", k), 128'(req_ready), 128'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 128'(resp_valid), 128'd0);
        check("bp_release_ready", 128'(req_ready), 128'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/vec_alu_ctrl.md
Name: vec_alu_ctrl

Overview:
Sequencer placed between the core's vector decode stage and an array of NLANES vec_alu lane instances. It accepts one vector arithmetic/logic request at a time, builds the lane operand buses, and drives per-lane run. It assembles lane outputs into a VLEN-bit result, tracks per-lane completion with a watchdog, and returns the result over a valid/ready handshake.

Parameters:
VLEN, 128, vector register width in bits
LANE_WIDTH, 4, log2 of lane datapath width (lane width LW = 2^LANE_WIDTH bits)
NLANES, 4, physical lanes attached (power of 2, max 4)
TIMEOUT, 1023, max RUN cycles before abort (10-bit counter)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_opcode  in  6  funct6 (000000 vadd, 001001 vand, 001010 vor, 001011 vxor)
req_op_type  in  3  001 VV, 010 VX, 100 VI
req_vsew  in  3  element width code (0..3 = 8..64 bits)
req_nb_lanes  in  2  log2 of lanes to use
req_vs1  in  VLEN  vector operand 1 (VV)
req_vs2  in  VLEN  vector operand 2
req_scalar  in  64  rs1 value (VX)
req_imm  in  5  simm5 (VI)
lane_run  out  NLANES  per-lane run
lane_opcode  out  6  registered opcode to all lanes
lane_vsew  out  3  registered vsew
lane_op_type  out  3  registered op_type
lane_nb_lanes  out  2  registered nb_lanes
lane_vs1  out  VLEN  built operand 1
lane_vs2  out  VLEN  registered vs2
lane_vd  in  NLANES*64  lane result, lane i at [64i +: 64]
lane_index  in  NLANES*10  lane bit offset, lane i at [10i +: 10]
lane_done  in  NLANES  lane done pulse
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_vd  out  VLEN  assembled result
resp_err  out  1  request aborted (illegal config or timeout)

Behaviour:
- States IDLE, RUN, RESP. Reset, from any state including mid-RUN: IDLE, lane_run=0, resp_valid=0, resp_err=0, resp_vd=0, sticky done bits=0, watchdog=0, all lane_* config/operand registers=0.
- IDLE: req_ready=1. On req_valid, latch opcode, op_type, vsew, nb_lanes, vs2; clear resp_vd, sticky bits, watchdog.
- Illegal request: vsew>3, op_type not one-hot, or 2^nb_lanes>NLANES. Go directly to RESP with resp_err=1, resp_vd=0. No lane is run.
- Legal request: go to RUN next cycle.
- lane_vs1 build:
  - VV: req_vs1.
  - VX: req_scalar truncated to SEW bits, zero-extended to VLEN.
  - VI: req_imm sign-extended to SEW bits, zero-extended to VLEN. Example: SEW=8, imm 5'b11110 gives low byte 0xFE.
- RUN:
  - lane_run[i]=1 for i<2^nb_lanes whose sticky done bit is clear; all other lanes 0.
  - Capture: each cycle, for each running lane with lane_done[i]=0, write lane_vd[i][LW-1:0] into resp_vd at bit offset lane_index[i]. Writes that would exceed VLEN are dropped.
  - A cycle with lane_done[i]=1 captures nothing and sets sticky[i]; lane i's run drops the next cycle.
  - When all active sticky bits are set: RESP, resp_err=0.
  - The watchdog increments each RUN cycle. Reaching TIMEOUT: drop all run, RESP, resp_err=1, partial resp_vd kept.
- RESP: resp_valid=1; resp_vd and resp_err are stable until resp_valid&&resp_ready. Then go to IDLE; resp_valid falls next cycle. req_ready=0 in RUN and RESP, so a new request is never accepted in the same cycle as a response handshake.
- Latency: acceptance at cycle T, first run at T+1. Response appears one cycle after the last sticky bit sets.
- lane_run is registered and glitch-free. Config and operands are held constant throughout RUN; lanes rely on this for carry chaining.

Test Plan:
- VV vadd, vsew=2, nb_lanes=1, vs1 elements 0x00000001, vs2 elements 0xFFFFFFFF -> resp_vd=0, resp_err=0, only lane_run[1:0] toggle.
- VV vand, vsew=0, nb_lanes=2, vs1=all 0xF0, vs2=all 0x3C -> resp_vd all bytes 0x30.
- VI vadd, vsew=0, imm=5'b11111, vs2 bytes 0x05 -> all bytes 0x04. VX vxor, vsew=1, scalar=0x1234_FFFF, vs2=0 -> all halfwords 0xFFFF.
- Request with vsew=3'b101, or nb_lanes=3 with NLANES=2 -> RESP within 2 cycles, resp_err=1, resp_vd=0, lane_run never asserted.
- Lanes stub never asserting done, TIMEOUT=16 -> resp_err=1 after 16 RUN cycles, all lane_run low.
- resetn low mid-RUN -> next cycle IDLE, lane_run=0, resp_valid=0. Hold resp_ready=0 for 5 cycles in RESP -> resp_vd stable, req_ready=0.
